// File: rtl/alu_bist.sv
// Built-in self-test initiator for the datapath ALU: drives an LFSR vector stream
// across the supported ops and compresses each result into a 32-bit MISR.
module alu_bist #(
   parameter int          PATTERNS = 16,
   parameter logic [31:0] SEED     = 32'h0000_0001,
   parameter logic [31:0] GOLDEN   = 32'h0000_0000,
   parameter logic [31:0] POLY     = 32'h04C1_1DB7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] signature,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_z
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int          CNT_W    = $clog2(PATTERNS) + 1;
   localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(PATTERNS - 1);
   localparam logic [2:0]  OP_LAST  = 3'd5;
   localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam logic [31:0] B_MASK   = 32'hA5A5_A5A5;

   logic [1:0]       state_q, state_d;
   logic [31:0]      lfsr_q, lfsr_d;
   logic [31:0]      sig_q, sig_d;
   logic [2:0]       op_idx_q, op_idx_d;
   logic [CNT_W-1:0] pat_q, pat_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [3:0]       alu_op_q, alu_op_d;
   logic [31:0]      alu_a_q, alu_a_d;
   logic [31:0]      alu_b_q, alu_b_d;

   logic [31:0]      lfsr_next;
   logic [31:0]      misr_next;

   // Shared Galois shift used by both the LFSR and the MISR.
   function automatic logic [31:0] galois_step(input logic [31:0] v);
      galois_step = {v[30:0], 1'b0} ^ (v[31] ? POLY : 32'h0);
   endfunction

   function automatic logic [3:0] op_of(input logic [2:0] idx);
      case (idx)
         3'd0:    op_of = 4'd0;
         3'd1:    op_of = 4'd1;
         3'd2:    op_of = 4'd2;
         3'd3:    op_of = 4'd6;
         3'd4:    op_of = 4'd7;
         3'd5:    op_of = 4'd12;
         default: op_of = 4'd0;
      endcase
   endfunction

   function automatic logic [31:0] operand_b(input logic [31:0] l);
      operand_b = {l[15:0], l[31:16]} ^ B_MASK;
   endfunction

   assign lfsr_next = galois_step(lfsr_q);
   assign misr_next = galois_step(sig_q) ^ alu_z;

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      sig_d    = sig_q;
      op_idx_d = op_idx_q;
      pat_d    = pat_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      alu_op_d = alu_op_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_RUN;
               lfsr_d   = SEED_EFF;
               sig_d    = 32'h0;
               op_idx_d = 3'd0;
               pat_d    = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
               alu_op_d = op_of(3'd0);
               alu_a_d  = SEED_EFF;
               alu_b_d  = operand_b(SEED_EFF);
            end
         end
         ST_RUN: begin
            // Every RUN edge absorbs the result of the vector currently on alu_*.
            sig_d = misr_next;
            if ((op_idx_q == OP_LAST) && (pat_q == PAT_LAST)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (misr_next == GOLDEN);
            end else begin
               if (pat_q == PAT_LAST) begin
                  pat_d    = '0;
                  op_idx_d = op_idx_q + 3'd1;
               end else begin
                  pat_d = pat_q + 1'b1;
               end
               lfsr_d   = lfsr_next;
               alu_op_d = op_of(op_idx_d);
               alu_a_d  = lfsr_next;
               alu_b_d  = operand_b(lfsr_next);
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         lfsr_q   <= SEED_EFF;
         sig_q    <= 32'h0;
         op_idx_q <= 3'd0;
         pat_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         alu_op_q <= 4'd0;
         alu_a_q  <= 32'h0;
         alu_b_q  <= 32'h0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         sig_q    <= sig_d;
         op_idx_q <= op_idx_d;
         pat_q    <= pat_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         alu_op_q <= alu_op_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig_q;
   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: vector-table compare plus golden, stuck-ALU,
// mid-run restart/reset and back-to-back run sequences.
module tb_alu_bist;

   localparam logic [31:0] POLY = 32'h04C1_1DB7;

   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         4'd0:    alu_fn = a & b;
         4'd1:    alu_fn = a | b;
         4'd2:    alu_fn = a + b;
         4'd6:    alu_fn = a - b;
         4'd7:    alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd12:   alu_fn = ~(a | b);
         default: alu_fn = 32'd0;
      endcase
   endfunction

   // Reference signature: walk the op table and stream in software.
   function automatic logic [31:0] model_sig(input int pats, input logic [31:0] seed,
                                             input bit flip);
      logic [31:0] l, s, a, b, z;
      logic [3:0]  op;
      l = (seed == 32'h0) ? 32'h1 : seed;
      s = 32'h0;
      for (int k = 0; k < 6; k++) begin
         case (k)
            0: op = 4'd0;
            1: op = 4'd1;
            2: op = 4'd2;
            3: op = 4'd6;
            4: op = 4'd7;
            default: op = 4'd12;
         endcase
         for (int p = 0; p < pats; p++) begin
            a = l;
            b = {l[15:0], l[31:16]} ^ 32'hA5A5_A5A5;
            z = alu_fn(op, a, b);
            if (flip && op == 4'd2) z[0] = ~z[0];
            s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ z;
            l = {l[30:0], 1'b0} ^ (l[31] ? POLY : 32'h0);
         end
      end
      model_sig = s;
   endfunction

   localparam logic [31:0] GOLD      = model_sig(2, 32'h1, 1'b0);
   localparam logic [31:0] GOLD_FLIP = model_sig(2, 32'h1, 1'b1);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flip_mode = 1'b0;
   logic        busy, done, pass;
   logic [31:0] signature, alu_a, alu_b, alu_z;
   logic [3:0]  alu_op;
   logic        s_busy, s_done, s_pass;
   logic [31:0] s_signature, s_alu_a, s_alu_b;
   logic [3:0]  s_alu_op;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign alu_z = alu_fn(alu_op, alu_a, alu_b) ^ {31'h0, (flip_mode && alu_op == 4'd2)};

   alu_bist #(.PATTERNS(2), .SEED(32'h1), .GOLDEN(GOLD), .POLY(POLY)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
      .signature(signature), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z)
   );

   alu_bist #(.PATTERNS(2), .SEED(32'h1), .GOLDEN(32'h1), .POLY(POLY)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(s_busy), .done(s_done), .pass(s_pass),
      .signature(s_signature), .alu_op(s_alu_op), .alu_a(s_alu_a), .alu_b(s_alu_b),
      .alu_z(32'h0)
   );

   typedef struct {
      int          cyc;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"}, {31'h0, busy}, 32'h0);
      chk({tag, " done"}, {31'h0, done}, 32'h0);
      chk({tag, " pass"}, {31'h0, pass}, 32'h0);
      chk({tag, " sig"}, signature, 32'h0);
      chk({tag, " op"}, {28'h0, alu_op}, 32'h0);
      chk({tag, " a"}, alu_a, 32'h0);
      chk({tag, " b"}, alu_b, 32'h0);
   endtask

   // One full run; a second start is pulsed at cycle poke_at (0 = none).
   task automatic run(input string tag, input logic [31:0] exp_sig, input bit exp_pass,
                      input int poke_at);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, " sig cleared"}, signature, 32'h0);
      for (int c = 1; c <= 12; c++) begin
         chk({tag, " vec op"}, {28'h0, alu_op}, {28'h0, tbl[c-1].op});
         chk({tag, " vec a"}, alu_a, tbl[c-1].a);
         chk({tag, " vec b"}, alu_b, tbl[c-1].b);
         chk({tag, " busy in run"}, {31'h0, busy}, 32'h1);
         chk({tag, " done in run"}, {31'h0, done}, 32'h0);
         if (c == poke_at) start = 1'b1;
         tick();
         start = 1'b0;
      end
      chk({tag, " done"}, {31'h0, done}, 32'h1);
      chk({tag, " busy end"}, {31'h0, busy}, 32'h0);
      chk({tag, " pass"}, {31'h0, pass}, {31'h0, exp_pass});
      chk({tag, " sig"}, signature, exp_sig);
      chk({tag, " hold a"}, alu_a, tbl[11].a);
      chk({tag, " hold op"}, {28'h0, alu_op}, {28'h0, tbl[11].op});
      chk({tag, " stuck sig"}, s_signature, 32'h0);
      chk({tag, " stuck pass"}, {31'h0, s_pass}, 32'h0);
      chk({tag, " stuck done"}, {31'h0, s_done}, 32'h1);
      chk({tag, " stuck busy"}, {31'h0, s_busy}, 32'h0);
      chk({tag, " stuck a"}, s_alu_a, tbl[11].a);
      chk({tag, " stuck b"}, s_alu_b, tbl[11].b);
      chk({tag, " stuck op"}, {28'h0, s_alu_op}, {28'h0, tbl[11].op});
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{0,  4'd0,  32'h0000_0001, 32'hA5A4_A5A5};
      tbl[1]  = '{1,  4'd0,  32'h0000_0002, 32'hA5A7_A5A5};
      tbl[2]  = '{2,  4'd1,  32'h0000_0004, 32'hA5A1_A5A5};
      tbl[3]  = '{3,  4'd1,  32'h0000_0008, 32'hA5AD_A5A5};
      tbl[4]  = '{4,  4'd2,  32'h0000_0010, 32'hA5B5_A5A5};
      tbl[5]  = '{5,  4'd2,  32'h0000_0020, 32'hA585_A5A5};
      tbl[6]  = '{6,  4'd6,  32'h0000_0040, 32'hA5E5_A5A5};
      tbl[7]  = '{7,  4'd6,  32'h0000_0080, 32'hA525_A5A5};
      tbl[8]  = '{8,  4'd7,  32'h0000_0100, 32'hA4A5_A5A5};
      tbl[9]  = '{9,  4'd7,  32'h0000_0200, 32'hA7A5_A5A5};
      tbl[10] = '{10, 4'd12, 32'h0000_0400, 32'hA1A5_A5A5};
      tbl[11] = '{11, 4'd12, 32'h0000_0800, 32'hADA5_A5A5};

      // Reset and idle
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk_all_zero("idle");

      // Golden run with the true ALU
      run("golden", GOLD, 1'b1, 0);

      // Back-to-back restart from DONE
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b done drop", {31'h0, done}, 32'h0);
      chk("b2b busy", {31'h0, busy}, 32'h1);
      chk("b2b pass drop", {31'h0, pass}, 32'h0);
      for (int i = 0; i < 11; i++) tick();
      chk("b2b done timing", {31'h0, done}, 32'h0);
      tick();
      chk("b2b done", {31'h0, done}, 32'h1);
      chk("b2b sig", signature, GOLD);
      chk("b2b pass", {31'h0, pass}, 32'h1);

      // Corrupted ADD result bit
      flip_mode = 1'b1;
      run("flip", GOLD_FLIP, 1'b0, 0);
      chk("flip sig differs", {31'h0, (signature != GOLD)}, 32'h1);
      flip_mode = 1'b0;

      // Restart request mid-run is ignored
      run("poke", GOLD, 1'b1, 3);

      // Reset mid-run aborts at once
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("midrun busy before rst", {31'h0, busy}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrun rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk_all_zero("after rst");
      run("post rst", GOLD, 1'b1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
